// File: rtl/traffic_ctrl_nway_if.sv
// Lamp/sensor bundle for the N-way intersection controller.
interface traffic_ctrl_nway_if #(
  parameter int N_WAYS = 2
);
  localparam int CW = $clog2(N_WAYS);

  logic [N_WAYS-1:0] sense;
  logic              flash;
  logic [N_WAYS-1:0] green;
  logic [N_WAYS-1:0] yellow;
  logic [N_WAYS-1:0] red;
  logic [CW-1:0]     cur_way;
  logic [1:0]        phase;

  modport master (output sense, flash, input green, yellow, red, cur_way, phase);
  modport slave  (input sense, flash, output green, yellow, red, cur_way, phase);
endinterface

// File: rtl/traffic_ctrl_nway.sv
// Round-robin N-way intersection controller: per-way green min/max with sensor
// extension, yellow, all-red clearance, latched demand and flashing-yellow mode.
module traffic_ctrl_nway #(
  parameter int N_WAYS      = 2,
  parameter int TW          = 13,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_FLASH     = 3
) (
  input  logic                clk,
  input  logic                reset,
  traffic_ctrl_nway_if.slave  bus
);
  localparam int CW = $clog2(N_WAYS);
  localparam logic [TW-1:0] GMIN_END  = TW'(T_GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_END  = TW'(T_GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_END   = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] AR_END    = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] FLASH_END = TW'(T_FLASH - 1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [N_WAYS-1:0] req_q, req_d;
  logic              tog_q, tog_d;

  logic              other_req;
  logic              found;
  logic [CW-1:0]     cand;
  logic [CW-1:0]     next_way;
  logic [N_WAYS-1:0] green_o, yellow_o, red_o;

  // Scan starts after the current way and wraps back onto it last.
  always_comb begin
    other_req = 1'b0;
    for (int unsigned j = 0; j < N_WAYS; j++) begin
      if (CW'(j) != cur_q && req_q[j]) other_req = 1'b1;
    end
    found    = 1'b0;
    cand     = '0;
    next_way = CW'((32'(cur_q) + 32'd1) % N_WAYS);
    for (int unsigned k = 1; k <= N_WAYS; k++) begin
      cand = CW'((32'(cur_q) + k) % N_WAYS);
      if (!found && req_q[cand]) begin
        next_way = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    req_d   = req_q | bus.sense;
    if (phase_q == PH_GREEN) req_d[cur_q] = req_q[cur_q];

    if (bus.flash) begin
      if (phase_q != PH_FLASH) begin
        phase_d = PH_FLASH;
        cnt_d   = '0;
        tog_d   = 1'b1;
      end else if (cnt_q == FLASH_END) begin
        cnt_d = '0;
        tog_d = ~tog_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (phase_q)
        PH_GREEN: begin
          if (cnt_q >= GMIN_END && other_req &&
              (!bus.sense[cur_q] || cnt_q == GMAX_END)) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else if (cnt_q != GMAX_END) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PH_YELLOW: begin
          if (cnt_q == YEL_END) begin
            phase_d = PH_ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PH_ALLRED: begin
          if (cnt_q == AR_END) begin
            phase_d         = PH_GREEN;
            cur_d           = next_way;
            cnt_d           = '0;
            req_d[next_way] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_GREEN;
      cur_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      tog_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    green_o  = '0;
    yellow_o = '0;
    red_o    = '1;
    case (phase_q)
      PH_GREEN: begin
        green_o[cur_q] = 1'b1;
        red_o[cur_q]   = 1'b0;
      end
      PH_YELLOW: begin
        yellow_o[cur_q] = 1'b1;
        red_o[cur_q]    = 1'b0;
      end
      PH_FLASH: begin
        red_o    = '0;
        yellow_o = {N_WAYS{tog_q}};
      end
      default: ;
    endcase
  end

  assign bus.green   = green_o;
  assign bus.yellow  = yellow_o;
  assign bus.red     = red_o;
  assign bus.cur_way = cur_q;
  assign bus.phase   = phase_q;
endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway with N_WAYS=3 and default timings.
module tb_traffic_ctrl_nway;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;

  traffic_ctrl_nway_if #(.N_WAYS(N)) bus ();
  traffic_ctrl_nway #(.N_WAYS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] y;
    logic [2:0] r;
    logic [1:0] ph;
    logic [1:0] cw;
  } out_t;

  typedef struct {
    logic [2:0] sense;
    logic       flash;
    out_t       exp;
  } vec_t;

  function automatic out_t grn(int w);
    out_t o;
    o.g = 3'(1 << w); o.y = 3'b000; o.r = ~3'(1 << w); o.ph = 2'd0; o.cw = 2'(w);
    return o;
  endfunction

  function automatic out_t yel(int w);
    out_t o;
    o.g = 3'b000; o.y = 3'(1 << w); o.r = ~3'(1 << w); o.ph = 2'd1; o.cw = 2'(w);
    return o;
  endfunction

  function automatic out_t allred(int w);
    out_t o;
    o.g = 3'b000; o.y = 3'b000; o.r = 3'b111; o.ph = 2'd2; o.cw = 2'(w);
    return o;
  endfunction

  function automatic out_t fl(bit lit, int w);
    out_t o;
    o.g = 3'b000; o.y = lit ? 3'b111 : 3'b000; o.r = 3'b000; o.ph = 2'd3; o.cw = 2'(w);
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {bus.green, bus.yellow, bus.red, bus.phase, bus.cur_way};
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got g=%b y=%b r=%b ph=%0d cw=%0d, expected g=%b y=%b r=%b ph=%0d cw=%0d",
                  name, act.g, act.y, act.r, act.ph, act.cw, exp.g, exp.y, exp.r, exp.ph, exp.cw);
  endtask

  task automatic step(input logic [2:0] s, input logic f);
    bus.sense = s;
    bus.flash = f;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input int n, input out_t exp);
    for (int i = 0; i < n; i++) begin
      step(3'b000, 1'b0);
      check(name, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bus.sense = '0;
    bus.flash = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl[11];

  initial begin
    // single demand on way 1: 4 green, 2 yellow, 1 all-red, then rest on way 1
    tbl[0]  = '{3'b010, 1'b0, grn(0)};
    tbl[1]  = '{3'b000, 1'b0, grn(0)};
    tbl[2]  = '{3'b000, 1'b0, grn(0)};
    tbl[3]  = '{3'b000, 1'b0, yel(0)};
    tbl[4]  = '{3'b000, 1'b0, yel(0)};
    tbl[5]  = '{3'b000, 1'b0, allred(0)};
    tbl[6]  = '{3'b000, 1'b0, grn(1)};
    tbl[7]  = '{3'b000, 1'b0, grn(1)};
    tbl[8]  = '{3'b000, 1'b0, grn(1)};
    tbl[9]  = '{3'b000, 1'b0, grn(1)};
    tbl[10] = '{3'b000, 1'b0, grn(1)};

    do_reset();
    check("reset_state", grn(0));
    run("idle_rest", 20, grn(0));

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sense, tbl[i].flash);
      check($sformatf("table_%0d", i), tbl[i].exp);
    end

    // sensor extension up to max green, then skip idle way 1
    do_reset();
    step(3'b101, 1'b0);
    check("ext_green_1", grn(0));
    for (int i = 2; i <= 7; i++) begin
      step(3'b001, 1'b0);
      check($sformatf("ext_green_%0d", i), grn(0));
    end
    step(3'b001, 1'b0); check("ext_yellow_0", yel(0));
    step(3'b000, 1'b0); check("ext_yellow_1", yel(0));
    step(3'b000, 1'b0); check("ext_allred", allred(0));
    step(3'b000, 1'b0); check("ext_skip_to_2", grn(2));

    // two demands at once: served 0 -> 1 -> 2
    do_reset();
    step(3'b110, 1'b0);
    check("rr_g0", grn(0));
    run("rr_g0", 2, grn(0));
    run("rr_y0", 2, yel(0));
    run("rr_ar0", 1, allred(0));
    run("rr_g1", 4, grn(1));
    run("rr_y1", 2, yel(1));
    run("rr_ar1", 1, allred(1));
    run("rr_g2", 3, grn(2));

    // flash in 3rd green cycle, toggle every 3 cycles, then exit via all-red
    do_reset();
    step(3'b000, 1'b0);
    check("fl_pre", grn(0));
    for (int i = 0; i < 7; i++) begin
      step(3'b000, 1'b1);
      check($sformatf("fl_%0d", i), fl((i / 3) % 2 == 0, 0));
    end
    step(3'b000, 1'b0); check("fl_exit_allred", allred(0));
    step(3'b000, 1'b0); check("fl_exit_green1", grn(1));

    // reset during yellow discards pending demand
    do_reset();
    step(3'b010, 1'b0);
    run("rst_g0", 2, grn(0));
    step(3'b000, 1'b0); check("rst_y0", yel(0));
    step(3'b100, 1'b0); check("rst_y1", yel(0));
    reset = 1'b0;
    step(3'b000, 1'b0);
    check("rst_mid", grn(0));
    reset = 1'b1;
    run("rst_no_req", 10, grn(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_nway.md
Name: traffic_ctrl_nway

Overview:
- Parametrised successor to the two-way sensor-driven intersection controller.
- Serves N_WAYS approaches round-robin. Each green has a minimum time, is extended by its own approach sensor up to a maximum, and is followed by yellow and an all-red clearance.
- Adds latched per-way demand, skipping of idle approaches, and a flashing-yellow maintenance mode.
- Timer and FSM live in one block; it replaces the separate timer/fsm pair at the top level.

Parameters:
- N_WAYS, 2: number of approaches, 2..8.
- TW, 13: state-timer counter width.
- T_GREEN_MIN, 4: minimum green, in cycles (>=1).
- T_GREEN_MAX, 8: maximum green while other ways have demand (>=T_GREEN_MIN).
- T_YELLOW, 2: yellow duration, in cycles (>=1).
- T_ALLRED, 1: all-red clearance, in cycles (>=1).
- T_FLASH, 3: half-period of the flashing yellow, in cycles (>=1).
- All T_* values are < 2^TW.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- sense  in  N_WAYS  per-way vehicle sensor, level, sampled each cycle
- flash  in  1  maintenance request; all ways flash yellow while high
- green  out  N_WAYS  per-way green lamp
- yellow  out  N_WAYS  per-way yellow lamp
- red  out  N_WAYS  per-way red lamp
- cur_way  out  $clog2(N_WAYS)  index of the way owning the current or last phase
- phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=FLASH

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: reset==0 sampled at a clk rising edge resets the block.
- Reset values:
  - phase=GREEN, cur_way=0, cnt=0, req=0, flash toggle bit=0.
  - green=one-hot bit 0; red=all ones except bit 0; yellow=0.
- All outputs are registered and decoded from the state registers. There is no combinational path from inputs to outputs.
- Exactly one lamp per way is lit in GREEN/YELLOW/ALLRED.
- Timer (cnt): cleared to 0 on every phase change, otherwise +1 per cycle. In GREEN it saturates at T_GREEN_MAX-1 and never wraps.
- Demand latch req[i]:
  - Set when sense[i]=1, unless way i is in GREEN (the way currently being served).
  - Cleared in the cycle the FSM enters GREEN for way i.
  - Set and clear in the same cycle: clear wins.
  - other_req = OR of req[j] for j != cur_way.
- GREEN(cur):
  - Leave to YELLOW when cnt >= T_GREEN_MIN-1 AND other_req AND (sense[cur]==0 OR cnt==T_GREEN_MAX-1).
  - With no other_req, green holds indefinitely (rest on green).
- YELLOW(cur): after T_YELLOW cycles (cnt==T_YELLOW-1), go to ALLRED.
- ALLRED:
  - After T_ALLRED cycles, go to GREEN(next).
  - next = first index k in cur+1, cur+2, ... (mod N_WAYS) with req[k]=1.
  - If no way has demand, next = (cur+1) mod N_WAYS.
  - cur_way updates on entry to GREEN.
- FLASH:
  - flash=1 in any phase forces FLASH on the next edge, mid-green or mid-yellow included.
  - In FLASH: green=0, red=0, yellow=all ones or all zeros; the toggle bit inverts every T_FLASH cycles, starting lit on entry.
  - When flash falls: go to ALLRED with cnt=0, then to GREEN(next) per the rule above.
  - req keeps latching during FLASH.
- Priority: reset > flash > timer transitions.
- Reset asserted mid-phase: returns to the reset values on that edge; pending req is discarded.

Test Plan:
- N_WAYS=3 defaults. Release reset, no sense activity for 20 cycles -> green=001 and red=110 held for all 20 cycles; phase=0 throughout.
- Pulse sense[1] for 1 cycle at cycle 0 -> green0 lasts exactly 4 cycles, then yellow=001 for 2, then red=111 for 1, then green=010 with cur_way=1; req[1] is cleared on that entry.
- sense[0]=1 held, sense[2] pulsed -> green0 extends to exactly 8 cycles (T_GREEN_MAX), then yellow; the following green goes to way 2 (way 1 is skipped because it has no demand).
- Pulse sense[1] and sense[2] in the same cycle while way 0 is green -> service order is 0 -> 1 -> 2; each green lasts 4 cycles and each is separated by 2 yellow + 1 all-red cycles.
- Assert flash during the 3rd green cycle -> next edge: green=000, red=000, yellow=111. Yellow then toggles every 3 cycles (111, 000, ...). Deassert flash -> 1 all-red cycle, then green=010 (rule (cur+1) mod N, no demand).
- Drive reset=0 for 1 cycle during YELLOW with req[2]=1 -> next cycle: green=001, red=110, req=000, phase=0, cur_way=0.
